fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 33 +++
 rtl/fetch_ir_reg.sv | 69 ++++++
 rtl/fetch_unit.sv | 155 +++++++++++++++
 tb/tb_fetch_unit.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared definitions for the instruction fetch unit: address and word
//   widths, the opcode field position, the default HALT opcode, the fetch
//   state encoding and a helper to extract the opcode field from a word.
//   Imported by fetch_unit and fetch_ir_reg.
// ----------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam int PC_WIDTH     = 26;
    localparam int INSTR_WIDTH  = 32;

    // Opcode occupies the top six bits of every instruction word.
    localparam int OPCODE_MSB   = 31;
    localparam int OPCODE_LSB   = 26;
    localparam int OPCODE_WIDTH = OPCODE_MSB - OPCODE_LSB + 1;

    localparam logic [OPCODE_WIDTH-1:0] HALT_OPCODE_DEFAULT = 6'b011000;

    // Fetch sequencer states. FETCH keeps the holding register topped up,
    // HALT stops fetching until resume, redirect or boot_done.
    typedef enum logic [0:0] {
        FS_FETCH = 1'b0,
        FS_HALT  = 1'b1
    } fetch_state_e;

    function automatic logic [OPCODE_WIDTH-1:0] opcode_of(
        input logic [INSTR_WIDTH-1:0] word
    );
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage : fetch_unit_pkg

// File: rtl/fetch_ir_reg.sv
// ----------------------------------------------------------------------------
// fetch_ir_reg
//   Instruction holding register between fetch and decode (ir, ir_pc,
//   ir_valid).
//
//   Handshake: the register offers ir/ir_pc while o_ir_valid=1; decode takes
//   it in any cycle where i_ready=1 and o_ir_valid=1. A new word may be
//   written (i_load) only when the slot is empty or is being taken in the
//   same cycle, which is what o_can_load reports. While o_ir_valid=1 and
//   i_ready=0 the contents are frozen.
//
//   Ports
//     i_clk       clock, rising edge
//     i_rst_n     synchronous active-low reset: clears everything to zero
//     i_flush     discard the held instruction (redirect / boot switch)
//     i_load      capture i_instr / i_pc this cycle
//     i_ready     decode accepts the held instruction this cycle
//     i_instr     word to capture
//     i_pc        address the word came from
//     o_ir        held instruction
//     o_ir_pc     address of the held instruction
//     o_ir_valid  held instruction not yet consumed
//     o_can_load  slot is free or being freed this cycle
// ----------------------------------------------------------------------------
module fetch_ir_reg
    import fetch_unit_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic                   i_load,
    input  logic                   i_ready,
    input  logic [INSTR_WIDTH-1:0] i_instr,
    input  logic [PC_WIDTH-1:0]    i_pc,
    output logic [INSTR_WIDTH-1:0] o_ir,
    output logic [PC_WIDTH-1:0]    o_ir_pc,
    output logic                   o_ir_valid,
    output logic                   o_can_load
);

    logic [INSTR_WIDTH-1:0] r_ir;
    logic [PC_WIDTH-1:0]    r_ir_pc;
    logic                   r_ir_valid;

    assign o_can_load = !r_ir_valid || i_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ir       <= '0;
            r_ir_pc    <= '0;
            r_ir_valid <= 1'b0;
        end else if (i_flush) begin
            // Data is left in place; only the valid flag matters downstream.
            r_ir_valid <= 1'b0;
        end else if (i_load) begin
            r_ir       <= i_instr;
            r_ir_pc    <= i_pc;
            r_ir_valid <= 1'b1;
        end else if (i_ready) begin
            // Taken by decode with nothing behind it (fetch is halted).
            r_ir_valid <= 1'b0;
        end
    end

    assign o_ir       = r_ir;
    assign o_ir_pc    = r_ir_pc;
    assign o_ir_valid = r_ir_valid;

endmodule : fetch_ir_reg

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Boots from a BIOS ROM, switches to instruction
//   memory on boot_done, follows redirects from execute, and stops on a HALT
//   opcode until resume. Fetched words are held in fetch_ir_reg for decode.
//
//   Optional feature: define FETCH_COUNT_EN to add the fetch_count output,
//   a free-running 32-bit count of fired fetches (reset only by reset).
//
//   Parameters
//     RESET_PC     instruction memory start address after boot_done
//     HALT_OPCODE  opcode field value that stops fetch
//
//   Ports
//     clock        sole clock, rising edge
//     reset        synchronous active-low reset
//     bios_pc      fetch address to BIOS ROM (always equals pc)
//     bios_instr   BIOS word, combinational from bios_pc
//     imem_pc      fetch address to instruction memory (always equals pc)
//     imem_instr   instruction memory word, combinational from imem_pc
//     boot_done    one-cycle pulse: leave BIOS, restart at RESET_PC in imem
//     redirect     taken jump/branch from execute
//     redirect_pc  redirect target
//     resume       leave HALT
//     ir_ready     decode accepts ir this cycle
//     ir           registered instruction
//     ir_pc        address ir was fetched from
//     ir_valid     ir holds an unconsumed instruction
//     boot_mode    1 while fetching from BIOS
//     halted       1 while in HALT (this is the state register itself)
//     fetch_count  fired fetch count (FETCH_COUNT_EN only)
//
//   Handshake: ir/ir_pc are offered while ir_valid=1 and taken on a cycle
//   with ir_ready=1; a fetch fires in FETCH whenever the slot is empty or
//   being taken, so one instruction per cycle streams with ir_ready held 1.
// ----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0]     RESET_PC    = 26'd0,
    parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
)(
    input  logic                   clock,
    input  logic                   reset,
    output logic [PC_WIDTH-1:0]    bios_pc,
    input  logic [INSTR_WIDTH-1:0] bios_instr,
    output logic [PC_WIDTH-1:0]    imem_pc,
    input  logic [INSTR_WIDTH-1:0] imem_instr,
    input  logic                   boot_done,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    input  logic                   resume,
    input  logic                   ir_ready,
    output logic [INSTR_WIDTH-1:0] ir,
    output logic [PC_WIDTH-1:0]    ir_pc,
    output logic                   ir_valid,
    output logic                   boot_mode,
    output logic                   halted
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0]            fetch_count
`endif
);

    localparam logic [0:0] ST_FETCH = FS_FETCH;
    localparam logic [0:0] ST_HALT  = FS_HALT;

    logic [PC_WIDTH-1:0]    r_pc;
    logic [0:0]             r_state;
    logic                   r_boot_mode;

    logic [INSTR_WIDTH-1:0] w_word;
    logic                   w_can_load;
    logic                   w_flush;
    logic                   w_fire;
    logic                   w_is_halt;

    assign bios_pc = r_pc;
    assign imem_pc = r_pc;

    assign w_word    = r_boot_mode ? bios_instr : imem_instr;
    assign w_is_halt = (opcode_of(w_word) == HALT_OPCODE);

    // Redirect and boot_done both restart fetch elsewhere, so anything in
    // the holding register belongs to the abandoned path.
    assign w_flush = redirect || boot_done;

    // A fetch only fires when nothing of higher priority claims the cycle.
    assign w_fire = (r_state == ST_FETCH) && w_can_load && !w_flush;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pc        <= '0;
            r_boot_mode <= 1'b1;
            r_state     <= ST_FETCH;
        end else if (redirect) begin
            r_pc    <= redirect_pc;
            r_state <= ST_FETCH;
            // A coincident boot_done still ends BIOS mode; only its pc
            // reload loses to the redirect target.
            if (boot_done) begin
                r_boot_mode <= 1'b0;
            end
        end else if (boot_done) begin
            r_pc        <= RESET_PC;
            r_boot_mode <= 1'b0;
            r_state     <= ST_FETCH;
        end else if (r_state == ST_HALT) begin
            // pc already points past the halt word, so resuming continues
            // with the next sequential instruction.
            if (resume) begin
                r_state <= ST_FETCH;
            end
        end else if (w_fire) begin
            r_pc <= r_pc + 26'd1;
            if (w_is_halt) begin
                r_state <= ST_HALT;
            end
        end
    end

    fetch_ir_reg u_ir_reg (
        .i_clk      (clock),
        .i_rst_n    (reset),
        .i_flush    (w_flush),
        .i_load     (w_fire),
        .i_ready    (ir_ready),
        .i_instr    (w_word),
        .i_pc       (r_pc),
        .o_ir       (ir),
        .o_ir_pc    (ir_pc),
        .o_ir_valid (ir_valid),
        .o_can_load (w_can_load)
    );

    assign boot_mode = r_boot_mode;
    assign halted    = (r_state == ST_HALT);

`ifdef FETCH_COUNT_EN
    logic [31:0] r_fetch_count;

    // Counts every fired fetch across redirects and the boot switch;
    // wraps naturally at 2^32.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_fetch_count <= '0;
        end else if (w_fire) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
`endif

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. BIOS and instruction memory are
//   64-entry arrays indexed by the low address bits. A behavioural model
//   steps the fetch rules once per cycle; a scoreboard queue holds the
//   instruction expected at decode and is popped on every accepted transfer.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [5:0] HALT_OP   = 6'b011000;
    localparam logic [31:0] HALT_WORD = 32'h6000_0000;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic [25:0] bios_pc;
    logic [31:0] bios_instr;
    logic [25:0] imem_pc;
    logic [31:0] imem_instr;
    logic        boot_done;
    logic        redirect;
    logic [25:0] redirect_pc;
    logic        resume;
    logic        ir_ready;
    logic [31:0] ir;
    logic [25:0] ir_pc;
    logic        ir_valid;
    logic        boot_mode;
    logic        halted;
`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    logic [31:0] bios_mem [64];
    logic [31:0] imem_mem [64];

    assign bios_instr = bios_mem[bios_pc[5:0]];
    assign imem_instr = imem_mem[imem_pc[5:0]];

    fetch_unit dut (
        .clock       (clock),
        .reset       (reset),
        .bios_pc     (bios_pc),
        .bios_instr  (bios_instr),
        .imem_pc     (imem_pc),
        .imem_instr  (imem_instr),
        .boot_done   (boot_done),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .resume      (resume),
        .ir_ready    (ir_ready),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_valid    (ir_valid),
        .boot_mode   (boot_mode),
        .halted      (halted)
`ifdef FETCH_COUNT_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    // ---------------- scoreboard / reference model ----------------
    int n_cmp = 0;
    int n_err = 0;

    logic [57:0] exp_q [$];   // {ir_pc, ir} expected at decode

    logic [25:0] m_pc;
    logic        m_boot;
    logic        m_halt;
    logic [31:0] m_ir;
    logic [25:0] m_ir_pc;
    logic        m_valid;
    logic [31:0] m_count;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_eq("bios_pc", bios_pc, m_pc);
        check_eq("imem_pc", imem_pc, m_pc);
        check_eq("ir_valid", ir_valid, m_valid);
        check_eq("ir_pc", ir_pc, m_ir_pc);
        check_eq("ir", ir, m_ir);
        check_eq("boot_mode", boot_mode, m_boot);
        check_eq("halted", halted, m_halt);
`ifdef FETCH_COUNT_EN
        check_eq("fetch_count", fetch_count, m_count);
`endif
    endtask

    // One clock: inputs are already set (we sit at a negedge).
    task automatic cycle();
        logic [25:0] n_pc;
        logic        n_boot, n_halt, n_valid;
        logic [31:0] n_ir, n_count, word;
        logic [25:0] n_ir_pc;

        // Decode takes the held instruction at this coming edge.
        if (ir_valid === 1'b1 && ir_ready) begin
            if (exp_q.size() == 0) check_eq("sb_empty", exp_q.size(), 1);
            else check_eq("sb", {ir_pc, ir}, exp_q.pop_front());
        end

        n_pc = m_pc; n_boot = m_boot; n_halt = m_halt; n_ir = m_ir;
        n_ir_pc = m_ir_pc; n_valid = m_valid; n_count = m_count;

        if (!reset) begin
            n_pc = 0; n_boot = 1; n_halt = 0; n_ir = 0; n_ir_pc = 0;
            n_valid = 0; n_count = 0;
            exp_q.delete();
        end else if (redirect) begin
            n_pc = redirect_pc; n_valid = 0; n_halt = 0;
            if (boot_done) n_boot = 0;
            exp_q.delete();
        end else if (boot_done) begin
            n_pc = 26'd0; n_boot = 0; n_valid = 0; n_halt = 0;
            exp_q.delete();
        end else if (m_halt) begin
            if (resume) n_halt = 0;
            if (ir_ready) n_valid = 0;
        end else if (!m_valid || ir_ready) begin
            word    = m_boot ? bios_mem[m_pc[5:0]] : imem_mem[m_pc[5:0]];
            n_ir    = word;
            n_ir_pc = m_pc;
            n_valid = 1;
            n_pc    = m_pc + 26'd1;
            n_count = m_count + 32'd1;
            if (word[31:26] == HALT_OP) n_halt = 1;
            exp_q.push_back({m_pc, word});
        end

        @(posedge clock);
        m_pc = n_pc; m_boot = n_boot; m_halt = n_halt; m_ir = n_ir;
        m_ir_pc = n_ir_pc; m_valid = n_valid; m_count = n_count;
        @(negedge clock);
        check_outputs();
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        redirect = 0; redirect_pc = 0; boot_done = 0; resume = 0;
    endtask

    task automatic do_reset();
        reset = 0;
        cycle();
        reset = 1;
    endtask

    task automatic fill_ramp();
        for (int k = 0; k < 64; k++) begin
            bios_mem[k] = 32'(k);
            imem_mem[k] = 32'h1000_0000 + 32'(k);
        end
        bios_mem[17] = HALT_WORD;
    endtask

    task automatic fill_random();
        logic [31:0] w;
        for (int k = 0; k < 64; k++) begin
            w = $urandom;
            if ($urandom_range(0, 7) == 0) w[31:26] = HALT_OP;
            else if (w[31:26] == HALT_OP) w[31:26] = 6'd0;
            bios_mem[k] = w;
            w = $urandom;
            if ($urandom_range(0, 7) == 0) w[31:26] = HALT_OP;
            else if (w[31:26] == HALT_OP) w[31:26] = 6'd1;
            imem_mem[k] = w;
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        m_pc = 0; m_boot = 1; m_halt = 0; m_ir = 0; m_ir_pc = 0;
        m_valid = 0; m_count = 0;
        reset = 0; ir_ready = 0;
        idle_inputs();
        fill_ramp();

        @(negedge clock);
        cycle();
        cycle();
        check_eq("rst_ir", ir, 0);
        check_eq("rst_ir_valid", ir_valid, 0);
        check_eq("rst_boot", boot_mode, 1);
        check_eq("rst_halted", halted, 0);
        check_eq("rst_pc", bios_pc, 0);

        // Sequential BIOS fetch: ir_pc 0,1,2 on the first three cycles.
        reset = 1; ir_ready = 1;
        cycle(); check_eq("seq_pc0", ir_pc, 0); check_eq("seq_boot", boot_mode, 1);
        cycle(); check_eq("seq_pc1", ir_pc, 1); check_eq("seq_ir1", ir, 1);
        cycle(); check_eq("seq_pc2", ir_pc, 2); check_eq("seq_ir2", ir, 2);

        // Stall three cycles, then release.
        ir_ready = 0;
        repeat (3) cycle();
        check_eq("stall_ir_pc", ir_pc, 2);
        check_eq("stall_ir", ir, 2);
        check_eq("stall_pc", bios_pc, 3);
        check_eq("stall_valid", ir_valid, 1);
        ir_ready = 1;
        cycle();
        check_eq("release_ir_pc", ir_pc, 3);

        // Halt word at address 17.
        repeat (14) cycle();
        check_eq("halt_ir_pc", ir_pc, 17);
        check_eq("halt_ir", ir, HALT_WORD);
        check_eq("halt_flag", halted, 1);
        check_eq("halt_pc", bios_pc, 18);
        cycle();
        check_eq("halt_consumed", ir_valid, 0);
        check_eq("halt_pc_hold", bios_pc, 18);
        check_eq("halt_still", halted, 1);
        resume = 1;
        cycle();
        resume = 0;
        check_eq("resume_halted", halted, 0);
        check_eq("resume_pc", bios_pc, 18);
        cycle();
        check_eq("resume_ir_pc", ir_pc, 18);

        // Reset in the middle of a stall.
        ir_ready = 0;
        cycle();
        do_reset();
        check_eq("mid_rst_valid", ir_valid, 0);
        check_eq("mid_rst_pc", bios_pc, 0);
        check_eq("mid_rst_ir_pc", ir_pc, 0);

        // boot_done at pc 5.
        ir_ready = 1;
        repeat (5) cycle();
        check_eq("boot_pre_pc", bios_pc, 5);
        boot_done = 1;
        cycle();
        boot_done = 0;
        check_eq("boot_valid", ir_valid, 0);
        check_eq("boot_mode_off", boot_mode, 0);
        check_eq("boot_imem_pc", imem_pc, 0);
        cycle();
        check_eq("boot_ir_pc", ir_pc, 0);
        check_eq("boot_ir", ir, 32'h1000_0000);

        // redirect + boot_done + halt word in the same cycle.
        do_reset();
        bios_mem[2] = HALT_WORD;
        repeat (2) cycle();
        redirect = 1; redirect_pc = 26'h0000F; boot_done = 1;
        cycle();
        idle_inputs();
        check_eq("rdb_pc", bios_pc, 26'h0000F);
        check_eq("rdb_boot", boot_mode, 0);
        check_eq("rdb_halted", halted, 0);
        check_eq("rdb_valid", ir_valid, 0);
        cycle();
        check_eq("rdb_ir_pc", ir_pc, 26'h0000F);
        check_eq("rdb_ir", ir, 32'h1000_000F);
        bios_mem[2] = 32'd2;

        // Reset while halted.
        do_reset();
        redirect = 1; redirect_pc = 26'd17;
        cycle();
        idle_inputs();
        cycle();
        check_eq("mh_halted", halted, 1);
        do_reset();
        check_eq("mh_rst_halted", halted, 0);
        check_eq("mh_rst_boot", boot_mode, 1);
        check_eq("mh_rst_pc", bios_pc, 0);

        // pc wrap at the top of the address space.
        redirect = 1; redirect_pc = 26'h3FFFFFE;
        cycle();
        idle_inputs();
        cycle();
        cycle();
        check_eq("wrap_ir_pc", ir_pc, 26'h3FFFFFF);
        check_eq("wrap_pc", bios_pc, 0);

        // Ten fires with two stall cycles.
        do_reset();
        ir_ready = 1;
        repeat (5) cycle();
        ir_ready = 0;
        repeat (2) cycle();
        ir_ready = 1;
        repeat (5) cycle();
        check_eq("cnt_ir_pc", ir_pc, 9);
`ifdef FETCH_COUNT_EN
        check_eq("cnt_10", fetch_count, 10);
`endif

        // Randomized traffic.
        fill_random();
        for (int i = 0; i < 3000; i++) begin
            ir_ready    = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 29) == 0);
            redirect_pc = 26'($urandom);
            boot_done   = ($urandom_range(0, 49) == 0);
            resume      = ($urandom_range(0, 3) == 0);
            reset       = !($urandom_range(0, 199) == 0);
            cycle();
        end
        reset = 1;
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fetch_unit
